// File: rtl/multibyte_add_ctrl.sv
// multibyte_add_ctrl: wide add/subtract built by time-sharing one external
// 8-bit adder slice, one byte per clock, least-significant byte first.
//
// Handshake: a request is accepted on a rising edge where start=1 and busy=0
// (IDLE or DONE). The operation then runs for NBYTES cycles with busy=1.
// done=1 for exactly one cycle, and result/cout/overflow are valid in that
// cycle. start while busy=1 is ignored.
module multibyte_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                cin,
  input  logic                sub,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                overflow,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_ci,
  input  logic [7:0]          add_sum,
  input  logic                add_co
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // state is kept as a plainly named signal so checkers can bind to it
  state_t state, state_nxt;

  logic [NBYTES-1:0][7:0] a_q;     // latched op_a
  logic [NBYTES-1:0][7:0] b_q;     // latched op_b, pre-inverted for subtract
  logic [NBYTES-1:0][7:0] res_q;   // result, filled byte by byte
  logic                   carry_q; // carry chained between bytes
  logic [IW-1:0]          idx_q;   // byte currently on the adder slice
  logic                   cout_q;
  logic                   ovf_q;

  logic accept;
  logic last;

  assign accept = start && (state != RUN);
  assign last   = (idx_q == IW'(NBYTES - 1));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: DONE lasts one cycle unless a new request chains in
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, then byte-serial accumulation of the result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= sub ? ~op_b : op_b;
      carry_q <= sub ? 1'b1 : cin;
      idx_q   <= '0;
    end else if (state == RUN) begin
      res_q[idx_q] <= add_sum;
      carry_q      <= add_co;
      if (last) begin
        idx_q  <= '0;
        cout_q <= add_co;
        // signed overflow: operands agree in sign, result sign differs
        ovf_q  <= (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &&
                  (add_sum[7] != a_q[NBYTES-1][7]);
      end else begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

  // Adder slice inputs are owned only while running; otherwise held at 0
  always_comb begin
    add_a  = 8'h00;
    add_b  = 8'h00;
    add_ci = 1'b0;
    if (state == RUN) begin
      add_a  = a_q[idx_q];
      add_b  = b_q[idx_q];
      add_ci = carry_q;
    end
  end

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign result   = res_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// Testbench for multibyte_add_ctrl (NBYTES=4): directed corner cases plus
// random add/subtract traffic against an integer-arithmetic reference model.
module tb_multibyte_add_ctrl;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;
  localparam int CW     = W + 2;   // {overflow, cout, result}

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic         start = 1'b0;
  logic [W-1:0] op_a  = '0;
  logic [W-1:0] op_b  = '0;
  logic         cin   = 1'b0;
  logic         sub   = 1'b0;
  logic         busy, done, cout, overflow;
  logic [W-1:0] result;
  logic [7:0]   add_a, add_b, add_sum;
  logic         add_ci, add_co;

  // external 8-bit adder slice
  logic [8:0] slice;
  assign slice   = 9'(add_a) + 9'(add_b) + 9'(add_ci);
  assign add_sum = slice[7:0];
  assign add_co  = slice[8];

  multibyte_add_ctrl #(.NBYTES(NBYTES)) dut (
    .clock(clock), .reset(reset), .start(start),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .overflow(overflow), .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_sum(add_sum), .add_co(add_co)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [CW-1:0] got,
                       input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the whole words
  function automatic logic [CW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ci, input logic s);
    longint sa, sb, sv, ua, ub, uv;
    logic co, ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    if (s) begin
      sv = sa - sb;
      uv = ua - ub;
      co = (ua >= ub);
    end else begin
      sv = sa + sb + longint'(ci);
      uv = ua + ub + longint'(ci);
      co = (uv >= 64'sh1_0000_0000);
    end
    ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    return {ov, co, uv[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge: present a request, let it be accepted, then scramble
  // the operand inputs and check the first byte put on the adder slice.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic s);
    logic [W-1:0] beff;
    beff = s ? ~b : b;
    exp_q.push_back(model(a, b, ci, s));
    op_a = a; op_b = b; cin = ci; sub = s; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    check("busy_after_start", CW'(busy), CW'(1'b1));
    check("add_a_byte0",  CW'(add_a),  CW'(a[7:0]));
    check("add_b_byte0",  CW'(add_b),  CW'(beff[7:0]));
    check("add_ci_byte0", CW'(add_ci), CW'(s ? 1'b1 : ci));
  endtask

  // Continue from the first post-accept negedge until done; optionally fire
  // an ignored start with other operands mid-run.
  task automatic wait_done(input bit poke);
    int cycles;
    logic [CW-1:0] exp;
    cycles = 1;
    while (!done && cycles < 40) begin
      @(negedge clock);
      cycles++;
      if (poke && cycles == 2) begin
        start = 1'b1; op_a = $urandom; op_b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    check("done_seen", CW'(done), CW'(1'b1));
    check("latency", CW'(cycles), CW'(NBYTES + 1));
    check("busy_in_done", CW'(busy), CW'(1'b0));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("result_word", {overflow, cout, result}, exp);
  endtask

  task automatic check_idle_zero_ports();
    check("idle_add_ports", CW'({add_a, add_b, add_ci}), '0);
  endtask

  // ---------------- main sequence ----------------
  logic [CW-1:0] held;
  initial begin
    #2;
    check("reset_outputs",
          {busy, done, result, cout, overflow} == '0 ? CW'(0) : CW'(1), CW'(0));
    check("reset_add_ports", CW'({add_a, add_b, add_ci}), '0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // carry ripples from byte 0 into byte 1
    launch(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done(1'b0);
    // full wrap and signed overflow
    launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done(1'b0);
    launch(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done(1'b0);
    // subtract ignores cin
    launch(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    wait_done(1'b0);
    check("sub_result", CW'(result), CW'(32'hFFFF_FFFE));

    // ignored start during RUN, then back-to-back start in the DONE cycle
    launch(32'hA5A5_1234, 32'h0F0F_FFFF, 1'b1, 1'b0);
    wait_done(1'b1);
    launch(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    wait_done(1'b0);

    // one-cycle done pulse, results hold, adder ports released
    held = {overflow, cout, result};
    @(negedge clock);
    check("done_one_cycle", CW'(done), CW'(1'b0));
    check("result_hold", {overflow, cout, result}, held);
    check_idle_zero_ports();

    // random traffic
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h7FFF_FFFF ^ W'($urandom_range(0, 3));
      launch(ra, rb, 1'($urandom), 1'($urandom));
      wait_done($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) @(negedge clock);
    end
    @(negedge clock);

    // reset abort after two RUN cycles
    launch(32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort_outputs",
          {busy, done, result, cout, overflow} == '0 ? CW'(0) : CW'(1), CW'(0));
    check("abort_add_ports", CW'({add_a, add_b, add_ci}), '0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clock);
      check("abort_no_done", CW'(done), CW'(1'b0));
    end
    reset = 1'b0;
    @(negedge clock);
    check("post_abort_idle", CW'({busy, done}), '0);
    launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_done(1'b0);
    check("post_abort_result", CW'({cout, result}), CW'({1'b0, 32'h2345_6789}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
